pocket_i2s_rx: RTL and testbench

- I2S receiver for the Analogue Pocket; the capture-side counterpart of the core's I2S audio transmitter.
- Accepts an externally clocked I2S stream (bit clock, word select, serial data) that is asynchronous to iCLK_74.
- Oversamples the stream in the iCLK_74 domain and deserialises it into left/right samples.
- Presents each completed stereo pair with a one-cycle valid strobe and reports link lock/loss.

---
 rtl/pocket_i2s_rx.sv | 196 +++++++++++++++++++
 tb/tb_pocket_i2s_rx.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pocket_i2s_rx.sv
// Philips I2S receiver: oversamples an asynchronous SCLK/LRCK/DAT stream in the
// iCLK_74 domain and presents each completed stereo pair with a one-cycle strobe.
module pocket_i2s_rx #(
    parameter int BITS    = 16,
    parameter int SIGNED  = 1,
    parameter int TIMEOUT = 256
) (
    input  logic            iCLK_74,
    input  logic            iRST,
    input  logic            I2S_SCLK,
    input  logic            I2S_LRCK,
    input  logic            I2S_DAT,
    output logic [BITS-1:0] AUDIO_L,
    output logic [BITS-1:0] AUDIO_R,
    output logic            AUDIO_VALID,
    output logic            LOCKED
);

    localparam int TW       = $clog2(TIMEOUT + 1);
    localparam int PIN_SCLK = 0;
    localparam int PIN_LRCK = 1;
    localparam int PIN_DAT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    logic [2:0] pin_w;
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic       sclk_hist_q, sclk_hist_d;

    logic       sclk_rise_w;
    logic       lrck_w;
    logic       dat_w;
    logic       lrck_change_w;
    logic       tmo_hit_w;

    state_t          state_q, state_d;
    logic            prev_lrck_q, prev_lrck_d;
    logic [BITS-1:0] shift_q, shift_d;
    logic [BITS-1:0] shift_bit_w;
    logic [BITS-1:0] sample_w;
    logic [5:0]      bitcnt_q, bitcnt_d;
    logic [5:0]      bitcnt_inc_w;
    logic [BITS-1:0] held_left_q, held_left_d;
    logic            have_left_q, have_left_d;
    logic [BITS-1:0] audio_l_q, audio_l_d;
    logic [BITS-1:0] audio_r_q, audio_r_d;
    logic            valid_q, valid_d;
    logic            locked_q, locked_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    assign pin_w = {I2S_DAT, I2S_LRCK, I2S_SCLK};

    always_comb begin
        sync1_d     = pin_w;
        sync2_d     = sync1_q;
        sclk_hist_d = sync2_q[PIN_SCLK];
    end

    // Synchroniser chain carries no reset so in-flight pin edges survive iRST.
    always_ff @(posedge iCLK_74) begin
        sync1_q     <= sync1_d;
        sync2_q     <= sync2_d;
        sclk_hist_q <= sclk_hist_d;
    end

    assign sclk_rise_w   = sync2_q[PIN_SCLK] & ~sclk_hist_q;
    assign lrck_w        = sync2_q[PIN_LRCK];
    assign dat_w         = sync2_q[PIN_DAT];
    assign lrck_change_w = (lrck_w != prev_lrck_q);

    // Shift register with the current bit already placed at its MSB-first slot.
    genvar gi;
    generate
        for (gi = 0; gi < BITS; gi++) begin : g_place
            assign shift_bit_w[gi] = (bitcnt_q == 6'(BITS - 1 - gi)) ? dat_w : shift_q[gi];
        end
    endgenerate

    always_comb begin
        sample_w = shift_bit_w;
        if (SIGNED == 0) begin
            sample_w[BITS-1] = ~shift_bit_w[BITS-1];
        end
    end

    assign bitcnt_inc_w = (bitcnt_q == 6'd63) ? bitcnt_q : bitcnt_q + 6'd1;

    assign tmo_hit_w = !sclk_rise_w && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (sclk_rise_w) begin
            tmo_d = '0;
        end else if (tmo_q != TW'(TIMEOUT)) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_lrck_d = prev_lrck_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        held_left_d = held_left_q;
        have_left_d = have_left_q;
        audio_l_d   = audio_l_q;
        audio_r_d   = audio_r_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;

        if (sclk_rise_w) begin
            case (state_q)
                ST_IDLE: begin
                    prev_lrck_d = lrck_w;
                    state_d     = ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (lrck_change_w) begin
                        prev_lrck_d = lrck_w;
                        shift_d     = '0;
                        bitcnt_d    = '0;
                        state_d     = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (lrck_change_w) begin
                        // This bit closes the old slot; commit it, then open the new one.
                        if (!prev_lrck_q) begin
                            held_left_d = sample_w;
                            have_left_d = 1'b1;
                        end else if (have_left_q) begin
                            audio_l_d   = held_left_q;
                            audio_r_d   = sample_w;
                            valid_d     = 1'b1;
                            locked_d    = 1'b1;
                            have_left_d = 1'b0;
                        end
                        prev_lrck_d = lrck_w;
                        shift_d     = '0;
                        bitcnt_d    = '0;
                    end else begin
                        shift_d  = shift_bit_w;
                        bitcnt_d = bitcnt_inc_w;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (tmo_hit_w) begin
            locked_d    = 1'b0;
            state_d     = ST_IDLE;
            have_left_d = 1'b0;
            bitcnt_d    = '0;
        end
    end

    always_ff @(posedge iCLK_74) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            prev_lrck_q <= 1'b0;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            held_left_q <= '0;
            have_left_q <= 1'b0;
            audio_l_q   <= '0;
            audio_r_q   <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            prev_lrck_q <= prev_lrck_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            held_left_q <= held_left_d;
            have_left_q <= have_left_d;
            audio_l_q   <= audio_l_d;
            audio_r_q   <= audio_r_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            tmo_q       <= tmo_d;
        end
    end

    assign AUDIO_L     = audio_l_q;
    assign AUDIO_R     = audio_r_q;
    assign AUDIO_VALID = valid_q;
    assign LOCKED      = locked_q;

endmodule

// File: tb/tb_pocket_i2s_rx.sv
// Bench for pocket_i2s_rx: drives Philips I2S frames and compares both a signed
// and an offset-binary instance against a bit-queue decoder model every cycle.
module tb_pocket_i2s_rx;

    localparam int BITS    = 16;
    localparam int TIMEOUT = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic lrck = 1'b0;
    logic dat = 1'b0;

    logic [15:0] l_s, r_s, l_u, r_u;
    logic        v_s, v_u, lk_s, lk_u;

    always #5 clk = ~clk;

    pocket_i2s_rx #(.BITS(BITS), .SIGNED(1), .TIMEOUT(TIMEOUT)) u_dut (
        .iCLK_74(clk), .iRST(rst), .I2S_SCLK(sclk), .I2S_LRCK(lrck), .I2S_DAT(dat),
        .AUDIO_L(l_s), .AUDIO_R(r_s), .AUDIO_VALID(v_s), .LOCKED(lk_s)
    );

    pocket_i2s_rx #(.BITS(BITS), .SIGNED(0), .TIMEOUT(TIMEOUT)) u_dut_u (
        .iCLK_74(clk), .iRST(rst), .I2S_SCLK(sclk), .I2S_LRCK(lrck), .I2S_DAT(dat),
        .AUDIO_L(l_u), .AUDIO_R(r_u), .AUDIO_VALID(v_u), .LOCKED(lk_u)
    );

    typedef struct {
        int   due;
        logic lr;
        logic d;
    } ev_t;

    ev_t  evq[$];
    logic dq[$];
    logic lq[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // reference decoder state: 0 idle, 1 align, 2 run
    int          mode = 0;
    logic        m_prev = 1'b0;
    logic        mbits[$];
    logic        m_have = 1'b0;
    logic [15:0] m_held = '0;
    logic [15:0] m_l = '0, m_r = '0, m_lu = '0, m_ru = '0;
    logic        m_valid = 1'b0, m_locked = 1'b0;
    int          last_ev = 0;

    int   last_due = 0;
    int   dut_strobes = 0;
    int   first_strobe_cyc = -1;
    int   lk_rise_cyc = -1;
    int   fall_cyc = -1;
    logic prev_lk = 1'b0;

    task automatic model_step();
        ev_t         e;
        logic [15:0] smp;
        bit          have_ev;
        cyc++;
        have_ev = (evq.size() > 0) && (evq[0].due == cyc);
        if (have_ev) e = evq.pop_front();
        if (rst) begin
            mode = 0; m_prev = 1'b0; mbits.delete(); m_have = 1'b0; m_held = '0;
            m_l = '0; m_r = '0; m_lu = '0; m_ru = '0; m_valid = 1'b0; m_locked = 1'b0;
            last_ev = cyc;
        end else if (have_ev) begin
            m_valid = 1'b0;
            last_ev = cyc;
            if (mode == 0) begin
                m_prev = e.lr;
                mode = 1;
            end else if (mode == 1) begin
                if (e.lr != m_prev) begin
                    m_prev = e.lr;
                    mbits.delete();
                    mode = 2;
                end
            end else begin
                if (mbits.size() < 64) mbits.push_back(e.d);
                if (e.lr != m_prev) begin
                    smp = '0;
                    for (int i = 0; i < BITS && i < mbits.size(); i++) smp[BITS-1-i] = mbits[i];
                    if (m_prev == 1'b0) begin
                        m_held = smp;
                        m_have = 1'b1;
                    end else if (m_have) begin
                        m_l = m_held; m_r = smp;
                        m_lu = m_held ^ 16'h8000; m_ru = smp ^ 16'h8000;
                        m_valid = 1'b1; m_locked = 1'b1; m_have = 1'b0;
                    end
                    mbits.delete();
                    m_prev = e.lr;
                end
            end
        end else begin
            m_valid = 1'b0;
            if (cyc - last_ev == TIMEOUT) begin
                m_locked = 1'b0; mode = 0; m_have = 1'b0; mbits.delete();
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_checks++;
            if ({l_s, r_s, v_s, lk_s} !== {m_l, m_r, m_valid, m_locked}) begin
                n_fail++;
                $display("FAIL signed_out cyc=%0d got L=%h R=%h V=%b LK=%b expected L=%h R=%h V=%b LK=%b",
                         cyc, l_s, r_s, v_s, lk_s, m_l, m_r, m_valid, m_locked);
            end
            n_checks++;
            if ({l_u, r_u, v_u, lk_u} !== {m_lu, m_ru, m_valid, m_locked}) begin
                n_fail++;
                $display("FAIL offset_out cyc=%0d got L=%h R=%h V=%b LK=%b expected L=%h R=%h V=%b LK=%b",
                         cyc, l_u, r_u, v_u, lk_u, m_lu, m_ru, m_valid, m_locked);
            end
            if (v_s === 1'b1) begin
                dut_strobes++;
                if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
            end
            if (lk_s === 1'b1 && prev_lk === 1'b0 && lk_rise_cyc < 0) lk_rise_cyc = cyc;
            if (lk_s === 1'b0 && prev_lk === 1'b1) fall_cyc = cyc;
            prev_lk = lk_s;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_bits(input logic lr, input logic [31:0] val, input int width,
                            input int skip, input int take);
        for (int k = skip; k < skip + take; k++) begin
            dq.push_back(val[width-1-k]);
            lq.push_back(lr);
        end
    endtask

    task automatic add_slot(input logic lr, input logic [31:0] val, input int width);
        add_bits(lr, val, width, 0, width);
    endtask

    // LRCK on the pins leads the slot by one bit: the last bit of a slot carries the next slot's LRCK.
    task automatic play(input int count, input int lo, input int hi, input bit rnd, input logic final_lr);
        for (int j = 0; j < count; j++) begin
            logic d, nxt;
            int   l, h;
            ev_t  e;
            d = dq.pop_front();
            void'(lq.pop_front());
            nxt = (lq.size() > 0) ? lq[0] : final_lr;
            l = rnd ? int'($urandom_range(2, 8)) : lo;
            h = rnd ? int'($urandom_range(2, 8)) : hi;
            sclk = 1'b0; lrck = nxt; dat = d;
            repeat (l) tick();
            sclk = 1'b1;
            e.due = cyc + 3; e.lr = nxt; e.d = d;
            evq.push_back(e);
            last_due = e.due;
            repeat (h) tick();
        end
    endtask

    task automatic gap();
        repeat (TIMEOUT + 40) tick();
    endtask

    initial begin
        int s0, stop_due, widths[5];
        widths = '{12, 16, 20, 24, 32};

        rst = 1'b1;
        repeat (5) tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_lit("reset_L", 32'(l_s), 32'h0);
        check_lit("reset_R", 32'(r_s), 32'h0);
        check_lit("reset_VALID", 32'(v_s), 32'h0);
        check_lit("reset_LOCKED", 32'(lk_s), 32'h0);
        tick();

        // nominal: 3 frames, 32-bit slots, 24-cycle SCLK
        s0 = dut_strobes;
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, 32'h1234_0000, 32);
            add_slot(1'b1, 32'hABCD_0000, 32);
        end
        play(dq.size(), 12, 12, 0, 1'b0);
        repeat (6) tick();
        check_lit("nominal_strobes", 32'(dut_strobes - s0), 32'd2);
        check_lit("nominal_L", 32'(l_s), 32'h1234);
        check_lit("nominal_R", 32'(r_s), 32'hABCD);
        check_lit("nominal_LOCKED", 32'(lk_s), 32'h1);
        check_lit("lock_rise_cycle", 32'(lk_rise_cyc), 32'(first_strobe_cyc));
        gap();

        // offset binary on the SIGNED=0 instance
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, 32'h8000_0000, 32);
            add_slot(1'b1, 32'h7FFF_0000, 32);
        end
        play(dq.size(), 0, 0, 1, 1'b0);
        repeat (6) tick();
        check_lit("offset_L", 32'(l_u), 32'h0000);
        check_lit("offset_R", 32'(r_u), 32'hFFFF);
        check_lit("signed_L", 32'(l_s), 32'h8000);
        check_lit("signed_R", 32'(r_s), 32'h7FFF);
        gap();

        // 12-bit slots are zero-filled below the MSBs
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, 32'h0000_0FFF, 12);
            add_slot(1'b1, 32'h0000_0123, 12);
        end
        play(dq.size(), 0, 0, 1, 1'b0);
        repeat (6) tick();
        check_lit("slot12_L", 32'(l_s), 32'hFFF0);
        check_lit("slot12_R", 32'(r_s), 32'h1230);
        gap();

        // 24-bit slots keep the top 16 bits
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, 32'h00A5_C37E, 24);
            add_slot(1'b1, 32'h000F_1E2D, 24);
        end
        play(dq.size(), 0, 0, 1, 1'b0);
        repeat (6) tick();
        check_lit("slot24_L", 32'(l_s), 32'hA5C3);
        check_lit("slot24_R", 32'(r_s), 32'h0F1E);
        gap();

        // loss: stop SCLK mid-left-slot after a locked frame
        for (int f = 0; f < 2; f++) begin
            add_slot(1'b0, 32'h1357_0000, 32);
            add_slot(1'b1, 32'h2468_0000, 32);
        end
        add_bits(1'b0, 32'h9999_0000, 32, 0, 10);
        play(dq.size(), 12, 12, 0, 1'b0);
        stop_due = last_due;
        fall_cyc = -1;
        s0 = dut_strobes;
        repeat (300) tick();
        check_lit("loss_fall_delay", 32'(fall_cyc - stop_due), 32'(TIMEOUT));
        check_lit("loss_no_strobe", 32'(dut_strobes - s0), 32'd0);
        check_lit("loss_L_held", 32'(l_s), 32'h1357);
        check_lit("loss_R_held", 32'(r_s), 32'h2468);
        check_lit("loss_LOCKED", 32'(lk_s), 32'h0);

        // recovery after restart
        s0 = dut_strobes;
        for (int f = 0; f < 3; f++) begin
            add_slot(1'b0, 32'h4242_0000, 32);
            add_slot(1'b1, 32'hBDBD_0000, 32);
        end
        play(dq.size(), 0, 0, 1, 1'b0);
        repeat (6) tick();
        check_lit("recover_strobes", 32'(dut_strobes - s0), 32'd2);
        check_lit("recover_L", 32'(l_s), 32'h4242);
        gap();

        // stream joins mid-left: first full right slot is dropped
        s0 = dut_strobes;
        add_bits(1'b0, 32'h5555_0000, 32, 27, 5);
        add_slot(1'b1, 32'hDEAD_0000, 32);
        add_slot(1'b0, 32'h600D_0000, 32);
        add_slot(1'b1, 32'hF00D_0000, 32);
        play(dq.size(), 0, 0, 1, 1'b0);
        repeat (6) tick();
        check_lit("rstart_strobes", 32'(dut_strobes - s0), 32'd1);
        check_lit("rstart_L", 32'(l_s), 32'h600D);
        check_lit("rstart_R", 32'(r_s), 32'hF00D);
        gap();

        // reset pulse inside a right slot
        add_slot(1'b0, 32'h1111_0000, 32); add_slot(1'b1, 32'h2222_0000, 32);
        add_slot(1'b0, 32'h3333_0000, 32); add_slot(1'b1, 32'h4444_0000, 32);
        add_slot(1'b0, 32'h5555_0000, 32); add_slot(1'b1, 32'h6666_0000, 32);
        add_slot(1'b0, 32'h7777_0000, 32); add_slot(1'b1, 32'h8888_0000, 32);
        play(170, 12, 12, 0, 1'b0);
        check_lit("prereset_L", 32'(l_s), 32'h3333);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_lit("midreset_L", 32'(l_s), 32'h0);
        check_lit("midreset_R", 32'(r_s), 32'h0);
        check_lit("midreset_VALID", 32'(v_s), 32'h0);
        check_lit("midreset_LOCKED", 32'(lk_s), 32'h0);
        tick();
        s0 = dut_strobes;
        play(dq.size(), 12, 12, 0, 1'b0);
        repeat (6) tick();
        check_lit("postreset_strobes", 32'(dut_strobes - s0), 32'd1);
        check_lit("postreset_L", 32'(l_s), 32'h7777);
        check_lit("postreset_R", 32'(r_s), 32'h8888);
        gap();

        // randomized slot widths, data and SCLK timing
        for (int f = 0; f < 6; f++) begin
            add_slot(1'b0, $urandom, widths[$urandom_range(0, 4)]);
            add_slot(1'b1, $urandom, widths[$urandom_range(0, 4)]);
        end
        play(dq.size(), 0, 0, 1, 1'b0);
        repeat (TIMEOUT + 10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
